// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared definitions for the pipeline hazard/stall controller.
//   state_t          : action taken in a cycle (RUN / STALL / FLUSH / WAIT)
//   DEFAULT_CNT_W    : default width of the performance counters
//   DEFAULT_TIMEOUT  : default consecutive-freeze limit before mem_timeout
// -----------------------------------------------------------------------------
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2,
    WAIT  = 2'd3
  } state_t;

  localparam int unsigned DEFAULT_CNT_W   = 16;
  localparam int unsigned DEFAULT_TIMEOUT = 255;

endpackage : hazard_pkg

// File: rtl/hazard_control_unit_if.sv
// -----------------------------------------------------------------------------
// hazard_control_unit_if
// Bundles the hazard-detection inputs coming from the ID/EX/MEM stages and the
// pipeline-register control outputs produced by the hazard control unit.
//   master : pipeline side (drives stage information, consumes controls)
//   slave  : hazard control unit (consumes stage information, drives controls)
// Signals:
//   IF_ID_Rs1/Rs2, IF_ID_UsesRs1/UsesRs2 : sources read by the ID instruction
//   ID_EX_Rd, ID_EX_RegWrite             : destination of the EX instruction
//   EX_BranchTaken                       : taken branch/jump resolved in EX
//   dmem_req, dmem_ready                 : MEM-stage data memory handshake
//   pc_write, if_id_write, if_id_flush,
//   id_ex_flush, pipe_hold               : pipeline register controls
//   dbg_state                            : action registered on the last edge
// -----------------------------------------------------------------------------
interface hazard_control_unit_if;
  import hazard_pkg::*;

  logic [4:0] IF_ID_Rs1;
  logic [4:0] IF_ID_Rs2;
  logic       IF_ID_UsesRs1;
  logic       IF_ID_UsesRs2;
  logic [4:0] ID_EX_Rd;
  logic       ID_EX_RegWrite;
  logic       EX_BranchTaken;
  logic       dmem_req;
  logic       dmem_ready;

  logic       pc_write;
  logic       if_id_write;
  logic       if_id_flush;
  logic       id_ex_flush;
  logic       pipe_hold;
  state_t     dbg_state;

  modport master (
    output IF_ID_Rs1, IF_ID_Rs2, IF_ID_UsesRs1, IF_ID_UsesRs2,
    output ID_EX_Rd, ID_EX_RegWrite, EX_BranchTaken, dmem_req, dmem_ready,
    input  pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_hold,
    input  dbg_state
  );

  modport slave (
    input  IF_ID_Rs1, IF_ID_Rs2, IF_ID_UsesRs1, IF_ID_UsesRs2,
    input  ID_EX_Rd, ID_EX_RegWrite, EX_BranchTaken, dmem_req, dmem_ready,
    output pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_hold,
    output dbg_state
  );

endinterface : hazard_control_unit_if

// File: rtl/hazard_control_unit_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at its all-ones value instead of wrapping.
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset, clears the count
//   inc   : count one event on this edge
//   q     : current count
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] q
);

  // Count events, holding at the maximum so software never sees a wrap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + 1'b1;
    end
  end

endmodule : sat_counter

// File: rtl/hazard_control_unit.sv
// -----------------------------------------------------------------------------
// hazard_control_unit
// Stall/flush/freeze controller for the 5-stage RISC-V pipeline. Forwarding only
// covers MEM/WB->EX, so a load-use style dependency on the EX-stage writer costs
// one bubble. Taken branches flush the wrong-path instruction in IF/ID and ID/EX,
// and a data-memory wait freezes the whole pipeline.
// Ports:
//   clk, rst_n   : clock and synchronous active-low reset
//   hz           : stage information in, pipeline controls out (slave modport)
//   stall_cnt    : saturating count of dependency-stall cycles
//   flush_cnt    : saturating count of branch-flush cycles
//   freeze_cnt   : saturating count of memory-freeze cycles
//   mem_timeout  : sticky flag, a single freeze lasted TIMEOUT cycles
// -----------------------------------------------------------------------------
module hazard_control_unit
  import hazard_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT,
  parameter int unsigned CNT_W   = DEFAULT_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  hazard_control_unit_if.slave hz,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     flush_cnt,
  output logic [CNT_W-1:0]     freeze_cnt,
  output logic                 mem_timeout
);

  // wait_len only needs to reach TIMEOUT-1, where it parks until the freeze ends.
  localparam int unsigned WL_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WL_W-1:0] WAIT_LAST = WL_W'(TIMEOUT - 1);

  state_t          state_q;
  state_t          next_state;
  logic            freeze;
  logic            dep;
  logic            rs1_hit;
  logic            rs2_hit;
  logic            pc_write;
  logic            if_id_write;
  logic            if_id_flush;
  logic            id_ex_flush;
  logic            pipe_hold;
  logic [WL_W-1:0] wait_len;

  // Hazard conditions. A write to x0 is never a real dependency.
  assign freeze  = hz.dmem_req & ~hz.dmem_ready;
  assign rs1_hit = hz.IF_ID_UsesRs1 & (hz.ID_EX_Rd == hz.IF_ID_Rs1);
  assign rs2_hit = hz.IF_ID_UsesRs2 & (hz.ID_EX_Rd == hz.IF_ID_Rs2);
  assign dep     = hz.ID_EX_RegWrite & (hz.ID_EX_Rd != 5'd0) & (rs1_hit | rs2_hit);

  // Action selection, highest priority first: reset, freeze, branch, dep, normal.
  // Controls depend only on this cycle's inputs; next_state records the action.
  always_comb begin
    next_state  = RUN;
    pc_write    = 1'b0;
    if_id_write = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    pipe_hold   = 1'b0;
    if (!rst_n) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      next_state  = RUN;
    end else if (freeze) begin
      pipe_hold   = 1'b1;
      next_state  = WAIT;
    end else if (hz.EX_BranchTaken) begin
      pc_write    = 1'b1;
      if_id_write = 1'b1;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      next_state  = FLUSH;
    end else if (dep) begin
      id_ex_flush = 1'b1;
      next_state  = STALL;
    end else begin
      pc_write    = 1'b1;
      if_id_write = 1'b1;
      next_state  = RUN;
    end
  end

  assign hz.pc_write    = pc_write;
  assign hz.if_id_write = if_id_write;
  assign hz.if_id_flush = if_id_flush;
  assign hz.id_ex_flush = id_ex_flush;
  assign hz.pipe_hold   = pipe_hold;
  assign hz.dbg_state   = state_q;

  // State register: remembers which action was taken on the last edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
    end else begin
      state_q <= next_state;
    end
  end

  // Freeze-length watchdog. The flag is sticky; the freeze itself is never
  // broken by it, the memory system still owns when the access completes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_len    <= '0;
      mem_timeout <= 1'b0;
    end else if (freeze) begin
      if (wait_len == WAIT_LAST) begin
        mem_timeout <= 1'b1;
      end else begin
        wait_len <= wait_len + 1'b1;
      end
    end else begin
      wait_len <= '0;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (next_state == STALL),
    .q     (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (next_state == FLUSH),
    .q     (flush_cnt)
  );

  sat_counter #(.W(CNT_W)) u_freeze_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (next_state == WAIT),
    .q     (freeze_cnt)
  );

endmodule : hazard_control_unit

// File: tb/tb_hazard_control_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_control_unit
// Directed bench for hazard_control_unit built with TIMEOUT=8 and CNT_W=3 so
// the watchdog and counter saturation are reachable in a few cycles.
// -----------------------------------------------------------------------------
module tb_hazard_control_unit;
  import hazard_pkg::*;

  localparam int unsigned TB_TIMEOUT = 8;
  localparam int unsigned TB_CNT_W   = 3;

  // Packed control word {pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_hold}
  localparam logic [4:0] C_NORMAL = 5'b11000;
  localparam logic [4:0] C_STALL  = 5'b00010;
  localparam logic [4:0] C_BRANCH = 5'b11110;
  localparam logic [4:0] C_FREEZE = 5'b00001;
  localparam logic [4:0] C_RESET  = 5'b00110;

  typedef struct {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       use1;
    logic       use2;
    logic [4:0] rd;
    logic       regwrite;
    logic       br;
    logic       req;
    logic       ready;
    logic       rst_n;
    logic [4:0] exp_ctrl;
  } vec_t;

  logic                clk;
  logic                rst_n;
  logic [TB_CNT_W-1:0] stall_cnt;
  logic [TB_CNT_W-1:0] flush_cnt;
  logic [TB_CNT_W-1:0] freeze_cnt;
  logic                mem_timeout;

  int compared;
  int mismatched;

  vec_t vecs [10];

  hazard_control_unit_if hz ();

  hazard_control_unit #(
    .TIMEOUT (TB_TIMEOUT),
    .CNT_W   (TB_CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .hz          (hz.slave),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt),
    .freeze_cnt  (freeze_cnt),
    .mem_timeout (mem_timeout)
  );

  // Free-running 10-time-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mkVec(
    input logic [4:0] rs1, input logic [4:0] rs2, input logic use1, input logic use2,
    input logic [4:0] rd, input logic regwrite, input logic br, input logic req,
    input logic ready, input logic rst, input logic [4:0] exp_ctrl);
    vec_t v;
    v.rs1 = rs1; v.rs2 = rs2; v.use1 = use1; v.use2 = use2;
    v.rd = rd; v.regwrite = regwrite; v.br = br; v.req = req;
    v.ready = ready; v.rst_n = rst; v.exp_ctrl = exp_ctrl;
    return v;
  endfunction

  // Drive one cycle's inputs just after the falling edge, then settle.
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    hz.IF_ID_Rs1      = v.rs1;
    hz.IF_ID_Rs2      = v.rs2;
    hz.IF_ID_UsesRs1  = v.use1;
    hz.IF_ID_UsesRs2  = v.use2;
    hz.ID_EX_Rd       = v.rd;
    hz.ID_EX_RegWrite = v.regwrite;
    hz.EX_BranchTaken = v.br;
    hz.dmem_req       = v.req;
    hz.dmem_ready     = v.ready;
    rst_n             = v.rst_n;
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: actual %0d required %0d", name, actual, expected);
    end
  endtask

  task automatic checkCtrl(input string name, input logic [4:0] expected);
    checkOutput(name, int'({hz.pc_write, hz.if_id_write, hz.if_id_flush,
                            hz.id_ex_flush, hz.pipe_hold}), int'(expected));
  endtask

  task automatic stepEdge();
    @(posedge clk);
    #1;
  endtask

  // Common input patterns for the hand-written sequences.
  function automatic vec_t vReset();
    return mkVec(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_RESET);
  endfunction

  function automatic vec_t vDep();
    return mkVec(5'd1, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, C_STALL);
  endfunction

  function automatic vec_t vIdle();
    return mkVec(5'd1, 5'd5, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, C_NORMAL);
  endfunction

  function automatic vec_t vFreeze(input logic br, input logic rst);
    return mkVec(5'd1, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, br, 1'b1, 1'b0, rst,
                 rst ? C_FREEZE : C_RESET);
  endfunction

  task automatic doReset();
    applyStimulus(vReset());
    stepEdge();
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst_n = 1'b0;
    hz.IF_ID_Rs1 = '0; hz.IF_ID_Rs2 = '0; hz.IF_ID_UsesRs1 = 1'b0; hz.IF_ID_UsesRs2 = 1'b0;
    hz.ID_EX_Rd = '0; hz.ID_EX_RegWrite = 1'b0; hz.EX_BranchTaken = 1'b0;
    hz.dmem_req = 1'b0; hz.dmem_ready = 1'b0;

    // Single-cycle vectors: rs1, rs2, use1, use2, rd, regwrite, br, req, ready, rst_n, controls
    vecs[0] = mkVec(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_RESET);
    vecs[1] = mkVec(5'd3, 5'd5, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, C_NORMAL);
    vecs[2] = mkVec(5'd3, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, C_STALL);
    vecs[3] = mkVec(5'd7, 5'd2, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, C_STALL);
    vecs[4] = mkVec(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, C_NORMAL);
    vecs[5] = mkVec(5'd9, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, C_NORMAL);
    vecs[6] = mkVec(5'd4, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, C_BRANCH);
    vecs[7] = mkVec(5'd4, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, C_FREEZE);
    vecs[8] = mkVec(5'd4, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, C_BRANCH);
    vecs[9] = mkVec(5'd4, 5'd6, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, C_NORMAL);

    // Table pass: one cycle per vector, controls checked combinationally.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i]);
      checkCtrl($sformatf("vec%0d_ctrl", i), vecs[i].exp_ctrl);
      stepEdge();
      if (i == 0) begin
        checkOutput("reset_stall_cnt", int'(stall_cnt), 0);
        checkOutput("reset_state", int'(hz.dbg_state), int'(RUN));
        checkOutput("reset_timeout", int'(mem_timeout), 0);
      end
    end
    checkOutput("table_stall_cnt", int'(stall_cnt), 2);
    checkOutput("table_flush_cnt", int'(flush_cnt), 2);
    checkOutput("table_freeze_cnt", int'(freeze_cnt), 1);

    // Dependency stall lasts one cycle; the bubble lets the pipeline resume.
    doReset();
    applyStimulus(vDep());
    checkCtrl("dep_ctrl", C_STALL);
    stepEdge();
    checkOutput("dep_state", int'(hz.dbg_state), int'(STALL));
    applyStimulus(vIdle());
    checkCtrl("after_bubble_ctrl", C_NORMAL);
    stepEdge();
    checkOutput("dep_stall_cnt", int'(stall_cnt), 1);
    checkOutput("after_bubble_state", int'(hz.dbg_state), int'(RUN));

    // Freeze masks a pending branch; the branch goes through when ready rises.
    doReset();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(vFreeze(1'b1, 1'b1));
      checkCtrl($sformatf("freeze%0d_ctrl", i), C_FREEZE);
      stepEdge();
    end
    checkOutput("freeze_state", int'(hz.dbg_state), int'(WAIT));
    applyStimulus(mkVec(5'd1, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, C_BRANCH));
    checkCtrl("ready_branch_ctrl", C_BRANCH);
    stepEdge();
    checkOutput("freeze_freeze_cnt", int'(freeze_cnt), 4);
    checkOutput("freeze_flush_cnt", int'(flush_cnt), 1);
    checkOutput("freeze_stall_cnt", int'(stall_cnt), 0);
    checkOutput("freeze_flush_state", int'(hz.dbg_state), int'(FLUSH));

    // Watchdog: flag sets on the 8th consecutive freeze edge and is sticky.
    doReset();
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(vFreeze(1'b0, 1'b1));
      stepEdge();
      if (i == 7) checkOutput("timeout_edge7", int'(mem_timeout), 0);
      if (i == 8) checkOutput("timeout_edge8", int'(mem_timeout), 1);
    end
    checkOutput("freeze_cnt_sat", int'(freeze_cnt), 7);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(vIdle());
      stepEdge();
    end
    checkOutput("timeout_sticky", int'(mem_timeout), 1);

    // Reset in the middle of a freeze wins immediately.
    applyStimulus(vFreeze(1'b0, 1'b1));
    stepEdge();
    applyStimulus(vFreeze(1'b1, 1'b0));
    checkCtrl("reset_mid_freeze_ctrl", C_RESET);
    stepEdge();
    checkOutput("reset_mid_freeze_timeout", int'(mem_timeout), 0);
    checkOutput("reset_mid_freeze_cnt", int'(freeze_cnt), 0);
    checkOutput("reset_mid_freeze_state", int'(hz.dbg_state), int'(RUN));
    // The freeze-length count restarted, so 7 more freeze edges stay clean.
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vFreeze(1'b0, 1'b1));
      stepEdge();
    end
    checkOutput("timeout_after_reset", int'(mem_timeout), 0);

    // Stall counter saturates at 2^3-1.
    doReset();
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vDep());
      stepEdge();
    end
    checkOutput("stall_cnt_sat", int'(stall_cnt), 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_hazard_control_unit

// File: doc/hazard_control_unit.md
# hazard_control_unit

Pipeline hazard and stall controller for the 5-stage RISC-V core, sitting beside the EX-stage forwarding logic and driving the PC and the IF/ID and ID/EX pipeline registers. Forwarding covers only MEM/WB→EX, so this block inserts one bubble when the instruction in ID depends on a writer currently in EX. It also flushes wrong-path instructions on a taken branch and freezes the whole pipeline while data memory is not ready. It keeps saturating performance counters and a sticky memory-timeout flag.

## Interface
- `TIMEOUT`, 255: consecutive freeze cycles before `mem_timeout` sets.
- `CNT_W`, 16: width of the performance counters.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `IF_ID_Rs1`, `IF_ID_Rs2` in 5: source registers of the instruction in ID.
- `IF_ID_UsesRs1`, `IF_ID_UsesRs2` in 1: the ID instruction actually reads that source.
- `ID_EX_Rd` in 5: destination register of the instruction in EX.
- `ID_EX_RegWrite` in 1: the EX instruction writes the register file.
- `EX_BranchTaken` in 1: branch or jump resolved taken in EX this cycle.
- `dmem_req` in 1: the MEM stage is accessing data memory.
- `dmem_ready` in 1: data memory completes the access this cycle.
- `pc_write` out 1: PC loads its next value.
- `if_id_write` out 1: IF/ID register loads.
- `if_id_flush` out 1: IF/ID loads a NOP.
- `id_ex_flush` out 1: ID/EX loads a bubble with all control bits 0.
- `pipe_hold` out 1: ID/EX, EX/MEM and MEM/WB hold their contents.
- `stall_cnt`, `flush_cnt`, `freeze_cnt` out CNT_W: saturating event counters.
- `mem_timeout` out 1: sticky error flag.

## Operation
- Condition definitions:
  - freeze = `dmem_req` & ~`dmem_ready`.
  - dep = `ID_EX_RegWrite` & (`ID_EX_Rd` ≠ 0) & ((`IF_ID_UsesRs1` & `ID_EX_Rd` = `IF_ID_Rs1`) | (`IF_ID_UsesRs2` & `ID_EX_Rd` = `IF_ID_Rs2`)).
- Action priority, highest first: reset > freeze > branch > dep > normal.
- Reset action:
  - `pc_write`=0, `if_id_write`=0, `if_id_flush`=1, `id_ex_flush`=1, `pipe_hold`=0.
  - Counters 0, `mem_timeout`=0, state RUN.
- Freeze action:
  - `pc_write`=0, `if_id_write`=0, `pipe_hold`=1, both flushes 0.
  - `EX_BranchTaken` and dep are ignored. They are re-evaluated on the first cycle in which freeze is 0.
- Branch action:
  - `pc_write`=1, `if_id_write`=1, `if_id_flush`=1, `id_ex_flush`=1.
  - The wrong-path instruction in ID is discarded, so dep is ignored.
- Dep action:
  - `pc_write`=0, `if_id_write`=0, `id_ex_flush`=1, `pipe_hold`=0.
  - The bubble removes the dependency on the next cycle, so the stall is exactly one cycle.
- Normal action: `pc_write`=1, `if_id_write`=1, all other control outputs 0.
- FSM state register, states RUN / STALL / FLUSH / WAIT.
  - The state records the action taken this cycle and updates on every edge.
  - The next state is WAIT, FLUSH, STALL or RUN for the freeze, branch, dep or normal action respectively.
  - Outputs are a function of the current inputs only. The state feeds the counters and debug.
- `stall_cnt` increments on each dep-action cycle.
- `flush_cnt` increments on each branch-action cycle.
- `freeze_cnt` increments on each freeze cycle.
- All counters saturate at 2^CNT_W−1 and never wrap.
- `wait_len` is an internal register counting consecutive freeze cycles.
  - It clears on any non-freeze cycle.
  - When `wait_len` = TIMEOUT−1 and freeze holds, `mem_timeout` sets on that edge.
  - `mem_timeout` clears only on reset. The freeze continues regardless.

## Timing
- All control outputs are combinational from the same cycle's inputs, with zero latency.
- Counters, state and `mem_timeout` update on the rising edge of `clk`.
- `rst_n` is sampled at the edge. While `rst_n`=0, the control outputs show the reset action combinationally.
- A reset asserted mid-freeze or mid-stall takes effect at that edge. There is no resumption of the interrupted action.
- If `dmem_ready` rises while a branch is pending, that same cycle takes the branch action.

## Structure
- Shared package `hazard_pkg`:
  - state enum {RUN, STALL, FLUSH, WAIT}.
  - Default widths for CNT_W and TIMEOUT.
- Sub-module `sat_counter` (parameter W; ports `clk`, `rst_n`, `inc`, `q`).
  - Instantiated three times for the performance counters.

## Test plan
- ID_EX_RegWrite=1, Rd=5; IF_ID_Rs2=5, UsesRs2=1 → one cycle with pc_write=0, id_ex_flush=1; next cycle normal; stall_cnt=1.
- Same as the first case but Rd=0, or UsesRs2=0 → no stall; stall_cnt=0.
- EX_BranchTaken=1 together with a dep match → if_id_flush=1, id_ex_flush=1, pc_write=1; flush_cnt=1, stall_cnt=0.
- dmem_req=1, dmem_ready=0 for 4 cycles with EX_BranchTaken=1 → pipe_hold=1 for 4 cycles; branch action on cycle 5; freeze_cnt=4.
- TIMEOUT=8, freeze held 10 cycles → mem_timeout rises after the 8th freeze edge and stays 1 after ready; clears only when rst_n=0.
- CNT_W=3, 9 stall events → stall_cnt saturates at 7; reset mid-freeze → all outputs take reset values at that edge.
